// File: rtl/nios2_dbg_seq_pkg.sv
//------------------------------------------------------------------------------
// Module  : nios2_dbg_seq_pkg
// Brief   : Shared constants, state encoding and command decode for the
//           Nios II debug command sequencer.
// Rev     : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

package nios2_dbg_seq_pkg;

    localparam int DATA_W = 38;
    localparam int CMD_W  = 40;

    localparam logic [1:0] IR_OCIMEM    = 2'd0;
    localparam logic [1:0] IR_TRACEMEM  = 2'd1;
    localparam logic [1:0] IR_BREAK     = 2'd2;
    localparam logic [1:0] IR_TRACECTRL = 2'd3;

    localparam logic [1:0] SUB_A = 2'd0;
    localparam logic [1:0] SUB_B = 2'd1;
    localparam logic [1:0] SUB_C = 2'd2;

    localparam int TA_BRK_A      = 0;
    localparam int TA_BRK_B      = 1;
    localparam int TA_BRK_C      = 2;
    localparam int TA_OCIMEM_A   = 3;
    localparam int TA_OCIMEM_B   = 4;
    localparam int TA_TRACECTRL  = 5;
    localparam int TA_TRACEMEM_A = 6;
    localparam int TA_TRACEMEM_B = 7;

    localparam int TNA_BRK_A      = 0;
    localparam int TNA_BRK_B      = 1;
    localparam int TNA_BRK_C      = 2;
    localparam int TNA_OCIMEM_A   = 3;
    localparam int TNA_TRACEMEM_A = 4;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_ISSUE    = 2'd1,
        ST_WAIT_MON = 2'd2
    } state_t;

    typedef struct packed {
        logic       legal;
        logic [7:0] ta;
        logic [4:0] tna;
    } decode_t;

    function automatic decode_t decode_cmd(input logic [1:0] ir,
                                           input logic       act,
                                           input logic [1:0] sub);
        decode_t d;
        d = '0;
        case (ir)
            IR_BREAK: begin
                d.legal = 1'b1;
                case (sub)
                    SUB_A:   if (act) d.ta[TA_BRK_A] = 1'b1; else d.tna[TNA_BRK_A] = 1'b1;
                    SUB_B:   if (act) d.ta[TA_BRK_B] = 1'b1; else d.tna[TNA_BRK_B] = 1'b1;
                    SUB_C:   if (act) d.ta[TA_BRK_C] = 1'b1; else d.tna[TNA_BRK_C] = 1'b1;
                    default: d.legal = 1'b0;
                endcase
            end
            IR_OCIMEM: begin
                if (act && sub == SUB_A)       d.ta[TA_OCIMEM_A]   = 1'b1;
                else if (act && sub == SUB_B)  d.ta[TA_OCIMEM_B]   = 1'b1;
                else if (!act && sub == SUB_A) d.tna[TNA_OCIMEM_A] = 1'b1;
                d.legal = |{d.ta, d.tna};
            end
            IR_TRACEMEM: begin
                if (act && sub == SUB_A)       d.ta[TA_TRACEMEM_A]   = 1'b1;
                else if (act && sub == SUB_B)  d.ta[TA_TRACEMEM_B]   = 1'b1;
                else if (!act && sub == SUB_A) d.tna[TNA_TRACEMEM_A] = 1'b1;
                d.legal = |{d.ta, d.tna};
            end
            default: begin
                if (act && sub == SUB_A) d.ta[TA_TRACECTRL] = 1'b1;
                d.legal = |d.ta;
            end
        endcase
        return d;
    endfunction

endpackage

`default_nettype wire

// File: rtl/nios2_dbg_cmd_fifo.sv
//------------------------------------------------------------------------------
// Module  : nios2_dbg_cmd_fifo
// Brief   : Synchronous FIFO of {ir,data} debug commands with full/empty flags.
// Rev     : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module nios2_dbg_cmd_fifo
    import nios2_dbg_seq_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [CMD_W-1:0] wdata,
    output logic [CMD_W-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    // Extra pointer MSB distinguishes full from empty when the indices match
    logic [AW:0]      r_wptr;
    logic [AW:0]      r_rptr;
    logic [CMD_W-1:0] r_mem [DEPTH];

    assign empty = (r_wptr == r_rptr);
    assign full  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
    assign rdata = r_mem[r_rptr[AW-1:0]];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (push && !full) r_wptr <= r_wptr + 1'b1;
            if (pop && !empty) r_rptr <= r_rptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push && !full) r_mem[r_wptr[AW-1:0]] <= wdata;
    end

endmodule

`default_nettype wire

// File: rtl/nios2_dbg_cmd_sequencer.sv
//------------------------------------------------------------------------------
// Module  : nios2_dbg_cmd_sequencer
// Brief   : Buffers debug commands and issues one take_action/take_no_action
//           strobe each; OCI memory actions wait for the monitor handshake.
//           Optional macro NIOS2_DBG_SEQ_TIMEOUT_EN adds a monitor wait timeout.
// Rev     : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module nios2_dbg_cmd_sequencer
    import nios2_dbg_seq_pkg::*;
#(
    parameter int FIFO_DEPTH     = 2,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_ir,
    input  logic [DATA_W-1:0] cmd_data,
    output logic [DATA_W-1:0] jdo,
    output logic [7:0]        take_action,
    output logic [4:0]        take_no_action,
    input  logic              monitor_ready,
    input  logic              monitor_error,
    output logic              busy,
    output logic              sts_error,
    output logic              sts_illegal,
`ifdef NIOS2_DBG_SEQ_TIMEOUT_EN
    output logic              sts_timeout,
`endif
    input  logic              sts_clr
);

    state_t            r_state;
    state_t            w_next_state;
    logic              w_full;
    logic              w_empty;
    logic              w_push;
    logic              w_pop;
    logic [CMD_W-1:0]  w_head;
    decode_t           w_dec;
    logic              w_set_error;
    logic              w_set_illegal;
    logic              w_timeout;
    logic              r_wait_mon;
    logic [DATA_W-1:0] r_jdo;
    logic [7:0]        r_take_action;
    logic [4:0]        r_take_no_action;
    logic              r_sts_error;
    logic              r_sts_illegal;

    assign w_push = cmd_valid & ~w_full;
    assign w_pop  = (r_state == ST_IDLE) & ~w_empty;
    assign w_dec  = decode_cmd(w_head[39:38], w_head[37], w_head[36:35]);

    nios2_dbg_cmd_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (w_push),
        .pop   (w_pop),
        .wdata ({cmd_ir, cmd_data}),
        .rdata (w_head),
        .full  (w_full),
        .empty (w_empty)
    );

    assign w_set_illegal = w_pop & ~w_dec.legal;
    assign w_set_error   = (r_state == ST_WAIT_MON) & monitor_ready & monitor_error;

`ifdef NIOS2_DBG_SEQ_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES) + 1;

    logic [TO_W-1:0] r_to_cnt;
    logic            r_sts_timeout;

    // Completion on the final cycle takes priority over timing out
    assign w_timeout = (r_state == ST_WAIT_MON) & ~monitor_ready &
                       (r_to_cnt == TO_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_to_cnt      <= '0;
            r_sts_timeout <= 1'b0;
        end else begin
            if (r_state == ST_ISSUE)         r_to_cnt <= '0;
            else if (r_state == ST_WAIT_MON) r_to_cnt <= r_to_cnt + 1'b1;
            r_sts_timeout <= (r_sts_timeout & ~sts_clr) | w_timeout;
        end
    end

    assign sts_timeout = r_sts_timeout;
`else
    assign w_timeout = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= ST_IDLE;
        else       r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE:     if (w_pop && w_dec.legal) w_next_state = ST_ISSUE;
            ST_ISSUE:    w_next_state = r_wait_mon ? ST_WAIT_MON : ST_IDLE;
            ST_WAIT_MON: if (monitor_ready || w_timeout) w_next_state = ST_IDLE;
            default:     w_next_state = ST_IDLE;
        endcase
    end

    // Strobes are registered at pop so they are high exactly during ISSUE
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_jdo            <= '0;
            r_take_action    <= '0;
            r_take_no_action <= '0;
            r_wait_mon       <= 1'b0;
            r_sts_error      <= 1'b0;
            r_sts_illegal    <= 1'b0;
        end else begin
            r_take_action    <= '0;
            r_take_no_action <= '0;
            if (w_pop) begin
                r_jdo      <= w_head[DATA_W-1:0];
                r_wait_mon <= (w_head[39:38] == IR_OCIMEM) & w_head[37];
                if (w_dec.legal) begin
                    r_take_action    <= w_dec.ta;
                    r_take_no_action <= w_dec.tna;
                end
            end
            r_sts_error   <= (r_sts_error & ~sts_clr) | w_set_error;
            r_sts_illegal <= (r_sts_illegal & ~sts_clr) | w_set_illegal;
        end
    end

    assign cmd_ready      = ~w_full;
    assign busy           = (r_state != ST_IDLE) | ~w_empty;
    assign jdo            = r_jdo;
    assign take_action    = r_take_action;
    assign take_no_action = r_take_no_action;
    assign sts_error      = r_sts_error;
    assign sts_illegal    = r_sts_illegal;

endmodule

`default_nettype wire

// File: tb/tb_nios2_dbg_cmd_sequencer.sv
//------------------------------------------------------------------------------
// Module  : tb_nios2_dbg_cmd_sequencer
// Brief   : Self-checking bench: decode table plus multi-cycle sequences,
//           strobes checked against a scoreboard queue.
// Rev     : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_nios2_dbg_cmd_sequencer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [1:0]  cmd_ir = 2'd0;
    logic [37:0] cmd_data = '0;
    logic [37:0] jdo;
    logic [7:0]  take_action;
    logic [4:0]  take_no_action;
    logic        monitor_ready = 1'b0;
    logic        monitor_error = 1'b0;
    logic        busy;
    logic        sts_error;
    logic        sts_illegal;
    logic        sts_clr = 1'b0;
`ifdef NIOS2_DBG_SEQ_TIMEOUT_EN
    logic        sts_timeout;
`endif

    nios2_dbg_cmd_sequencer #(
        .FIFO_DEPTH     (2),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .cmd_valid      (cmd_valid),
        .cmd_ready      (cmd_ready),
        .cmd_ir         (cmd_ir),
        .cmd_data       (cmd_data),
        .jdo            (jdo),
        .take_action    (take_action),
        .take_no_action (take_no_action),
        .monitor_ready  (monitor_ready),
        .monitor_error  (monitor_error),
        .busy           (busy),
        .sts_error      (sts_error),
        .sts_illegal    (sts_illegal),
`ifdef NIOS2_DBG_SEQ_TIMEOUT_EN
        .sts_timeout    (sts_timeout),
`endif
        .sts_clr        (sts_clr)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  ta;
        logic [4:0]  tna;
        logic [37:0] jdo;
    } exp_t;

    typedef struct {
        logic [1:0] ir;
        logic       act;
        logic [1:0] sub;
        logic [7:0] ta;
        logic [4:0] tna;
        logic       illegal;
    } vec_t;

    exp_t sb[$];
    vec_t vt[16];
    int   n_pass = 0;
    int   n_total = 0;
    int   n_strobe = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [37:0] mk(input logic act, input logic [1:0] sub, input logic [34:0] pl);
        return {act, sub, pl};
    endfunction

    task automatic expect_strobe(input logic [7:0] ta, input logic [4:0] tna, input logic [37:0] d);
        exp_t e;
        e.ta = ta; e.tna = tna; e.jdo = d;
        sb.push_back(e);
    endtask

    task automatic push_cmd(input logic [1:0] ir, input logic [37:0] d);
        int guard;
        guard = 0;
        cmd_ir = ir; cmd_data = d; cmd_valid = 1'b1;
        while (!cmd_ready && guard < 50) begin tick(); guard++; end
        check("push_ready", {63'd0, cmd_ready}, 64'd1);
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 50 && busy; i++) tick();
        check("idle", {63'd0, busy}, 64'd0);
    endtask

    // Every strobe cycle must match the oldest outstanding expectation
    always @(negedge clk) begin
        if (!reset && (take_action != 8'd0 || take_no_action != 5'd0)) begin
            n_strobe++;
            if (sb.size() == 0) begin
                check("unexpected_strobe", {51'd0, take_action, take_no_action}, 64'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("strobe", {51'd0, take_action, take_no_action}, {51'd0, e.ta, e.tna});
                check("strobe_jdo", {26'd0, jdo}, {26'd0, e.jdo});
            end
        end
    end

    initial begin
        logic [37:0] d;
        logic [37:0] d2;
        logic [37:0] d3;
        logic [37:0] d4;
        int          base;

        vt[0]  = '{2'd2, 1'b1, 2'd0, 8'h01, 5'h00, 1'b0};
        vt[1]  = '{2'd2, 1'b1, 2'd1, 8'h02, 5'h00, 1'b0};
        vt[2]  = '{2'd2, 1'b1, 2'd2, 8'h04, 5'h00, 1'b0};
        vt[3]  = '{2'd2, 1'b0, 2'd0, 8'h00, 5'h01, 1'b0};
        vt[4]  = '{2'd2, 1'b0, 2'd1, 8'h00, 5'h02, 1'b0};
        vt[5]  = '{2'd2, 1'b0, 2'd2, 8'h00, 5'h04, 1'b0};
        vt[6]  = '{2'd2, 1'b1, 2'd3, 8'h00, 5'h00, 1'b1};
        vt[7]  = '{2'd0, 1'b0, 2'd0, 8'h00, 5'h08, 1'b0};
        vt[8]  = '{2'd0, 1'b0, 2'd1, 8'h00, 5'h00, 1'b1};
        vt[9]  = '{2'd1, 1'b1, 2'd0, 8'h40, 5'h00, 1'b0};
        vt[10] = '{2'd1, 1'b1, 2'd1, 8'h80, 5'h00, 1'b0};
        vt[11] = '{2'd1, 1'b0, 2'd0, 8'h00, 5'h10, 1'b0};
        vt[12] = '{2'd1, 1'b0, 2'd1, 8'h00, 5'h00, 1'b1};
        vt[13] = '{2'd3, 1'b1, 2'd0, 8'h20, 5'h00, 1'b0};
        vt[14] = '{2'd3, 1'b1, 2'd1, 8'h00, 5'h00, 1'b1};
        vt[15] = '{2'd0, 1'b1, 2'd2, 8'h00, 5'h00, 1'b1};

        repeat (3) tick();
        check("rst_ready",   {63'd0, cmd_ready}, 64'd1);
        check("rst_jdo",     {26'd0, jdo}, 64'd0);
        check("rst_strobes", {51'd0, take_action, take_no_action}, 64'd0);
        check("rst_busy",    {63'd0, busy}, 64'd0);
        check("rst_sticky",  {62'd0, sts_error, sts_illegal}, 64'd0);
        reset = 1'b0;
        tick();

        // Latency: push at edge N, jdo after N+1, strobe during N+2, idle after N+2
        d = 38'h2A_0000_0001;
        expect_strobe(8'h02, 5'h00, d);
        cmd_ir = 2'd2; cmd_data = d; cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
        check("lat_no_strobe_early", {56'd0, take_action}, 64'd0);
        tick();
        check("lat_jdo",    {26'd0, jdo}, {26'd0, d});
        check("lat_strobe", {56'd0, take_action}, 64'h02);
        check("lat_busy",   {63'd0, busy}, 64'd1);
        tick();
        check("lat_strobe_off", {56'd0, take_action}, 64'd0);
        check("lat_busy_off",   {63'd0, busy}, 64'd0);

        for (int i = 0; i < 16; i++) begin
            d = mk(vt[i].act, vt[i].sub, 35'($urandom));
            if (!vt[i].illegal) expect_strobe(vt[i].ta, vt[i].tna, d);
            push_cmd(vt[i].ir, d);
            wait_idle();
            check("vec_jdo",     {26'd0, jdo}, {26'd0, d});
            check("vec_illegal", {63'd0, sts_illegal}, {63'd0, vt[i].illegal});
            sts_clr = 1'b1;
            tick();
            sts_clr = 1'b0;
        end
        check("error_clear", {63'd0, sts_error}, 64'd0);

        // OCIMEM stall with three commands queued behind it
        d  = mk(1'b1, 2'd0, 35'h123);
        d2 = mk(1'b1, 2'd2, 35'h456);
        d3 = mk(1'b1, 2'd0, 35'h789);
        d4 = mk(1'b0, 2'd1, 35'hABC);
        expect_strobe(8'h08, 5'h00, d);
        expect_strobe(8'h04, 5'h00, d2);
        expect_strobe(8'h40, 5'h00, d3);
        expect_strobe(8'h00, 5'h02, d4);
        base = n_strobe;
        push_cmd(2'd0, d);
        push_cmd(2'd2, d2);
        push_cmd(2'd1, d3);
        check("stall_full", {63'd0, cmd_ready}, 64'd0);
        cmd_ir = 2'd2; cmd_data = d4; cmd_valid = 1'b1;
        repeat (4) tick();
        check("stall_still_full", {63'd0, cmd_ready}, 64'd0);
        check("stall_one_strobe", 64'(n_strobe - base), 64'd1);
        monitor_ready = 1'b1; monitor_error = 1'b1;
        tick();
        monitor_ready = 1'b0; monitor_error = 1'b0;
        check("stall_sts_error", {63'd0, sts_error}, 64'd1);
        check("stall_no_early_issue", 64'(n_strobe - base), 64'd1);
        for (int i = 0; i < 20 && !cmd_ready; i++) tick();
        check("stall_ready_again", {63'd0, cmd_ready}, 64'd1);
        tick();
        cmd_valid = 1'b0;
        wait_idle();
        check("stall_all_issued", 64'(n_strobe - base), 64'd4);

        // Illegal TRACECTRL, then clear coinciding with a new illegal set
        push_cmd(2'd3, mk(1'b0, 2'd0, 35'h1));
        wait_idle();
        check("ill_set", {63'd0, sts_illegal}, 64'd1);
        push_cmd(2'd3, mk(1'b0, 2'd0, 35'h2));
        sts_clr = 1'b1;
        tick();
        sts_clr = 1'b0;
        check("ill_set_wins", {63'd0, sts_illegal}, 64'd1);
        sts_clr = 1'b1;
        tick();
        sts_clr = 1'b0;
        check("ill_cleared", {63'd0, sts_illegal}, 64'd0);
        push_cmd(2'd3, mk(1'b0, 2'd0, 35'h3));
        wait_idle();

        // Asynchronous reset while waiting on the monitor with one command queued
        d = mk(1'b1, 2'd1, 35'h55);
        expect_strobe(8'h10, 5'h00, d);
        push_cmd(2'd0, d);
        push_cmd(2'd2, mk(1'b1, 2'd0, 35'h66));
        tick();
        check("ar_busy_before", {63'd0, busy}, 64'd1);
        #2 reset = 1'b1;
        #1;
        sb.delete();
        check("ar_ready",   {63'd0, cmd_ready}, 64'd1);
        check("ar_jdo",     {26'd0, jdo}, 64'd0);
        check("ar_strobes", {51'd0, take_action, take_no_action}, 64'd0);
        check("ar_busy",    {63'd0, busy}, 64'd0);
        check("ar_sticky",  {62'd0, sts_error, sts_illegal}, 64'd0);
        tick();
        reset = 1'b0;
        base = n_strobe;
        repeat (8) tick();
        check("ar_no_issue", 64'(n_strobe - base), 64'd0);

`ifdef NIOS2_DBG_SEQ_TIMEOUT_EN
        d = mk(1'b1, 2'd0, 35'h77);
        expect_strobe(8'h08, 5'h00, d);
        push_cmd(2'd0, d);
        repeat (2) tick();
        repeat (15) tick();
        check("to_not_yet", {62'd0, busy, sts_timeout}, 64'h2);
        tick();
        check("to_fired", {62'd0, busy, sts_timeout}, 64'h1);
        sts_clr = 1'b1;
        tick();
        sts_clr = 1'b0;
        check("to_cleared", {63'd0, sts_timeout}, 64'd0);
`endif

        check("sb_drained", 64'(sb.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/nios2_dbg_cmd_sequencer.md
Name: nios2_dbg_cmd_sequencer

Overview:
- System-clock controller that sequences debug-slave actions for the Nios II CPU's on-chip debug logic.
- Accepts already-synchronized debug commands (IR code plus 38-bit data word) through a valid/ready handshake and buffers them in a small FIFO.
- Issues exactly one take_action / take_no_action strobe per command, holding jdo stable.
- For OCI memory actions, waits on the monitor_ready/monitor_error handshake before accepting the next command.

Parameters:
FIFO_DEPTH, 2, command buffer entries; power of two, minimum 2
TIMEOUT_CYCLES, 1024, monitor wait limit in clk cycles (used only with the optional feature)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous active-high reset
cmd_valid  in  1  command present
cmd_ready  out  1  FIFO not full
cmd_ir  in  2  0=OCIMEM 1=TRACEMEM 2=BREAK 3=TRACECTRL
cmd_data  in  38  [37]=act (1 action, 0 no-action); [36:35]=sub (0=a 1=b 2=c); [34:0] payload
jdo  out  38  data of the command being executed
take_action  out  8  one-hot pulse: [0]brk_a [1]brk_b [2]brk_c [3]ocimem_a [4]ocimem_b [5]tracectrl [6]tracemem_a [7]tracemem_b
take_no_action  out  5  one-hot pulse: [0]brk_a [1]brk_b [2]brk_c [3]ocimem_a [4]tracemem_a
monitor_ready  in  1  monitor completed OCI access (level)
monitor_error  in  1  monitor error, sampled with monitor_ready
busy  out  1  FSM not IDLE or FIFO non-empty
sts_error  out  1  sticky monitor error
sts_illegal  out  1  sticky: an illegal command was dropped
sts_clr  in  1  clears sticky status bits

Behaviour:
- Reset (asynchronous, any state) values: FSM=IDLE, FIFO flushed, cmd_ready=1, jdo=0, all strobes=0, busy=0, all sticky bits=0.
- Push: occurs when cmd_valid & cmd_ready. cmd_ready=0 when the FIFO is full; a push is refused even if a pop happens in the same cycle.
- IDLE:
  - FIFO non-empty: pop, load jdo<=data, latch ir/act/sub.
  - Legal command: go to ISSUE.
  - Illegal command: set sts_illegal, jdo still loaded, stay IDLE with no strobe.
- ISSUE: the single matching strobe is high for exactly this one cycle.
  - OCIMEM with act=1: next state WAIT_MON.
  - All other commands: next state IDLE.
- WAIT_MON:
  - First evaluated the cycle after the strobe.
  - When monitor_ready=1: sts_error |= monitor_error, go to IDLE.
  - monitor_ready already high at strobe time is still honoured the next cycle.
- Latency: push at edge N (empty FIFO, IDLE) -> jdo valid after edge N+1 -> strobe high during cycle N+2. Back-to-back non-OCIMEM commands issue every 2 cycles.
- jdo holds its value until the next pop.
- Legal set:
  - OCIMEM and TRACEMEM: act a/b; no-act a.
  - BREAK: act and no-act with sub a/b/c.
  - TRACECTRL: act with sub a only.
  - Every other combination, including sub=3, is illegal.
- sts_clr: clears the sticky bits. A set in the same cycle wins.
- FIFO pointers: (log2 FIFO_DEPTH)+1 bits; wrap-around is handled by the MSB compare.

Optional Feature:
- Macro: NIOS2_DBG_SEQ_TIMEOUT_EN.
- Defined:
  - Adds a counter cleared on entry to WAIT_MON.
  - If TIMEOUT_CYCLES cycles elapse without monitor_ready: set sts_timeout (extra output port, sticky, cleared by sts_clr), return to IDLE.
  - monitor_ready and timeout on the same cycle: treated as completion, no timeout.
- Undefined: no port, no counter; WAIT_MON waits indefinitely.

Decomposition:
- Package nios2_dbg_seq_pkg:
  - IR code constants.
  - Sub-op constants.
  - take_action / take_no_action index constants.
  - FSM state enum (IDLE, ISSUE, WAIT_MON).
  - CMD_W=40 packed command width.
- Sub-module nios2_dbg_cmd_fifo: synchronous FIFO holding 40-bit {ir,data} entries, with full/empty flags.

Test Plan:
- BREAK act sub b, data 0x2A_0000_0001 pushed at edge N -> take_action=8'h02 for one cycle in N+2; jdo=0x2A00000001 from N+1; busy drops in N+3.
- OCIMEM act a, monitor_ready raised 5 cycles after the strobe with monitor_error=1 -> take_action=8'h08 once; FSM in WAIT_MON 5 cycles; sts_error=1; next queued command strobes only after completion.
- Push 3 commands back-to-back while OCIMEM is stalled, FIFO_DEPTH=2 -> cmd_ready=0 after the 2nd push; third accepted only after a pop; all three execute in order.
- TRACECTRL with act=0 -> no strobe, sts_illegal=1; sts_clr and a simultaneous new illegal command -> sts_illegal stays 1.
- Reset asserted during WAIT_MON with 1 queued command -> all outputs return to reset values asynchronously; queued command never issues.
- With NIOS2_DBG_SEQ_TIMEOUT_EN and TIMEOUT_CYCLES=16, monitor_ready held 0 -> sts_timeout=1 and IDLE exactly 16 cycles after WAIT_MON entry.
